// File: rtl/booth2_pkg.sv
// Shared definitions for the radix-4 (Booth-2) multiplier family.
//   state_t     : control states of the sequential multiplier
//   digit_t     : recoded Booth digit selecting 0, +-A or +-2A
//   DEFAULT_WIDTH : default operand width
//   digit_count : number of radix-4 digits for a given operand width
package booth2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  localparam int DEFAULT_WIDTH = 8;

  // Each radix-4 digit consumes two multiplier bits.
  function automatic int digit_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth2_encoder.sv
// Booth-2 recoder and partial-product generator (combinational).
// Ports:
//   triplet : {b[2i+1], b[2i], b[2i-1]} for the digit being recoded
//   mcand   : multiplicand A, two's complement, WIDTH bits
//   digit   : recoded digit (ZERO, POS1, POS2, NEG1, NEG2)
//   pp      : signed partial product, WIDTH+2 bits
module booth2_encoder
  import booth2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH-1:0] mcand,
  output digit_t           digit,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] single;
  logic [WIDTH+1:0] double;

  // Two guard bits let 2A and -2A of the most negative multiplicand be
  // represented exactly before the negation.
  always_comb begin
    single = {{2{mcand[WIDTH-1]}}, mcand};
    double = {single[WIDTH:0], 1'b0};
    digit  = ZERO;
    pp     = '0;

    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase

    case (digit)
      POS1:    pp = single;
      POS2:    pp = double;
      NEG1:    pp = (~single) + (WIDTH+2)'(1);
      NEG2:    pp = (~double) + (WIDTH+2)'(1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth2_seq_mult.sv
// Iterative signed radix-4 (Booth-2) multiplier, one partial product per clock.
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : multiplicand and multiplier, two's complement
//   out_valid/out_ready : result handshake (out_valid high in DONE)
//   product             : signed 2*WIDTH-bit result, held until the next load
//   busy                : high while an operation is in CALC or DONE
module booth2_seq_mult
  import booth2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int NDIG = digit_count(WIDTH);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  digit_t             digit;
  logic [WIDTH+1:0]   pp;
  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] sum;
  logic               last_digit;

  // The multiplier register is shifted right two bits per digit, so the
  // current triplet always sits in its three low bits; bit 0 starts as b[-1].
  booth2_encoder #(
    .WIDTH(WIDTH)
  ) u_encoder (
    .triplet(mplier[2:0]),
    .mcand  (mcand),
    .digit  (digit),
    .pp     (pp)
  );

  assign pp_ext     = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
  assign sum        = acc + (pp_ext << {cnt, 1'b0});
  assign last_digit = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_digit) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Zero digits leave the accumulator untouched; the final sum is loaded into
  // product on the last digit and then held through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= {b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (digit != ZERO) acc <= sum;
          mplier <= mplier >> 2;
          cnt    <= cnt + CW'(1);
          if (last_digit) product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth2_seq_mult.sv
// Self-checking bench for booth2_seq_mult (WIDTH=8): directed vectors with
// hand-computed products, handshake/hold/abort scenarios and a random stream.
module tb_booth2_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int nTotal = 0;
  int nBad   = 0;

  logic [7:0]  vecA [6] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h7F};
  logic [7:0]  vecB [6] = '{8'h80, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h80};
  logic [15:0] vecP [6] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'h0001, 16'hC080};

  logic [15:0] expQ [$];

  booth2_seq_mult #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  // Free-running 10-unit clock; inputs are driven and outputs sampled on
  // the falling edge, well away from the active edge.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nTotal++;
    if (observed !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair from IDLE and waits for out_valid; lat returns
  // the number of falling edges between the accept edge and out_valid.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                               output int lat);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ready_wait", {31'b0, in_ready}, 32'd1);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~ta;
    b        = ~tb;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Completes the result handshake with a one-cycle out_ready pulse.
  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Directed sequence followed by a randomised stream.
  initial begin
    int lat;
    logic anyValid;
    int sent;
    int got;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #2 rst_n  = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_product", {16'b0, product}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3*5 with out_ready held high: check cycle-exact latency and return to IDLE.
    a         = 8'd3;
    b         = 8'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("calc_busy", {31'b0, busy}, 32'd1);
    checkOutput("calc_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lat_valid_%0d", k), {31'b0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("p_3x5", {16'b0, product}, 32'h000F);
    checkOutput("done_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("post_hs_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("post_hs_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Boundary operands, including the most negative multiplicand and multiplier.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecA[i], vecB[i], lat);
      checkOutput($sformatf("lat_vec%0d", i), lat, 32'd4);
      checkOutput($sformatf("p_vec%0d", i), {16'b0, product}, {16'b0, vecP[i]});
      releaseResult();
    end

    // Hold in DONE with out_ready low while new operands are offered.
    applyStimulus(8'd5, 8'hFD, lat);
    for (int k = 0; k < 5; k++) begin
      a        = 8'd99;
      b        = 8'd77;
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("hold_valid_%0d", k), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("hold_p_%0d", k), {16'b0, product}, 32'hFFF1);
      checkOutput($sformatf("hold_ready_%0d", k), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("hold_drop_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("hold_keep_p", {16'b0, product}, 32'hFFF1);
    @(negedge clk);
    checkOutput("hold_not_taken", {31'b0, busy}, 32'd0);

    // Reset during the second CALC cycle aborts the operation.
    a        = 8'd100;
    b        = 8'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort_product", {16'b0, product}, 32'h0);
    checkOutput("abort_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    anyValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      anyValid = anyValid | out_valid;
    end
    checkOutput("abort_no_pulse", {31'b0, anyValid}, 32'd0);
    applyStimulus(8'hF9, 8'd9, lat);
    checkOutput("lat_after_abort", lat, 32'd4);
    checkOutput("p_m7x9", {16'b0, product}, 32'hFFC1);
    releaseResult();

    // Random stream: the driver only presents real operands while in_ready is
    // high and scoreboards them; the consumer toggles out_ready at random.
    sent = 0;
    got  = 0;
    fork
      begin : driver
        logic signed [7:0]  ra;
        logic signed [7:0]  rb;
        logic signed [15:0] e;
        int cyc;
        cyc = 0;
        while (sent < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (in_ready && $urandom_range(0, 3) != 0) begin
            ra       = 8'($urandom);
            rb       = 8'($urandom);
            e        = ra * rb;
            a        = ra;
            b        = rb;
            in_valid = 1'b1;
            expQ.push_back(e);
            sent++;
          end else if (in_ready) begin
            in_valid = 1'b0;
          end else begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : monitor
        bit seen;
        int cyc;
        logic [15:0] exp;
        seen = 1'b0;
        cyc  = 0;
        while (got < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (out_valid && !seen) begin
            seen = 1'b1;
            checkOutput("stream_pending", {31'b0, (expQ.size() > 0)}, 32'd1);
            if (expQ.size() > 0) begin
              exp = expQ.pop_front();
              checkOutput($sformatf("stream_p_%0d", got), {16'b0, product}, {16'b0, exp});
            end
            got++;
          end
          if (!out_valid) seen = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) seen = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    checkOutput("stream_count", got, 32'd1000);
    checkOutput("stream_leftover", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
